// File: rtl/kcpsm_io_pkg.sv
// kcpsm_io_pkg: shared port-id defaults, interrupt FSM states and channel limits
package kcpsm_io_pkg;
  localparam int MAX_CH = 16;
  localparam logic [7:0] DEF_OUT_BASE = 8'h00;
  localparam logic [7:0] DEF_IN_BASE = 8'h00;
  localparam logic [7:0] DEF_IRQ_STAT_ID = 8'hF0;
  localparam logic [7:0] DEF_IRQ_MASK_ID = 8'hF1;
  localparam logic [7:0] DEF_WDOG_ID = 8'hF2;
  localparam int DEF_WDOG_CYCLES = 2 ** 20;
  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} irq_state_t;
endpackage

// File: rtl/kcpsm_irq_ctrl.sv
// kcpsm_irq_ctrl: rising-edge capture into W1C pending bits, enable mask and interrupt/ack handshake FSM
module kcpsm_irq_ctrl
  import kcpsm_io_pkg::*;
#(
  parameter int N_IRQ = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_src,
  input  logic             stat_wr,
  input  logic             mask_wr,
  input  logic [N_IRQ-1:0] wdata,
  input  logic             interrupt_ack,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] mask,
  output logic             interrupt
);
  irq_state_t state, state_nx;
  logic [N_IRQ-1:0] src_q;
  // edge detect, pending with set winning over a simultaneous W1C clear, mask and state register
  always_ff @(posedge clk)
    if (!reset) begin
      src_q <= '0;
      pending <= '0;
      mask <= '0;
      state <= IDLE;
    end else begin
      src_q <= irq_src;
      pending <= (pending & ~(stat_wr ? wdata : '0)) | (irq_src & ~src_q);
      if (mask_wr) mask <= wdata;
      state <= state_nx;
    end
  // a write to the status register marks the end of the ISR and re-arms the controller
  always_comb begin
    state_nx = state;
    if (state == IDLE && |(pending & mask)) state_nx = ASSERT;
    else if (state == ASSERT && interrupt_ack) state_nx = SERVICE;
    else if (state == SERVICE && stat_wr) state_nx = IDLE;
  end
  assign interrupt = state == ASSERT;
endmodule

// File: rtl/kcpsm_io_bridge.sv
// kcpsm_io_bridge: KCPSM6 port-mapped I/O decode, output registers, registered input mux, irq controller; optional watchdog via KCPSM_IO_WDOG_EN
module kcpsm_io_bridge
  import kcpsm_io_pkg::*;
#(
  parameter int         N_OUT       = 4,
  parameter int         N_IN        = 4,
  parameter int         N_IRQ       = 4,
  parameter logic [7:0] OUT_BASE    = DEF_OUT_BASE,
  parameter logic [7:0] IN_BASE     = DEF_IN_BASE,
  parameter logic [7:0] IRQ_STAT_ID = DEF_IRQ_STAT_ID,
  parameter logic [7:0] IRQ_MASK_ID = DEF_IRQ_MASK_ID,
  parameter logic [7:0] WDOG_ID     = DEF_WDOG_ID,
  parameter int         WDOG_CYCLES = DEF_WDOG_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         port_id,
  input  logic [7:0]         out_port,
  input  logic               write_strobe,
  input  logic               k_write_strobe,
  input  logic               read_strobe,
  output logic [7:0]         in_port,
  output logic               interrupt,
  input  logic               interrupt_ack,
  input  logic [8*N_IN-1:0]  ext_in,
  output logic [N_IN-1:0]    rd_pulse,
  output logic [8*N_OUT-1:0] out_data,
  output logic [N_OUT-1:0]   out_valid,
  input  logic [N_IRQ-1:0]   irq_src,
  output logic               wdog_rst
);
  logic wdog_hit, special, stat_wr, mask_wr;
  logic [N_IRQ-1:0] pending, mask;
  logic [N_OUT-1:0] wr_hit;
  logic [7:0] rd_mux;
`ifdef KCPSM_IO_WDOG_EN
  assign wdog_hit = port_id == WDOG_ID;
`else
  assign wdog_hit = 1'b0;
`endif
  assign special = port_id == IRQ_STAT_ID || port_id == IRQ_MASK_ID || wdog_hit;
  assign stat_wr = write_strobe && port_id == IRQ_STAT_ID;
  assign mask_wr = write_strobe && port_id == IRQ_MASK_ID;
  // OUTPUT hits its range unless a control id claims it; OUTPUTK only sees the low nibble
  always_comb
    for (int i = 0; i < N_OUT; i++)
      wr_hit[i] = (write_strobe && !special && port_id == OUT_BASE + 8'(i)) || (k_write_strobe && port_id[3:0] == 4'(i));
  // FIFO pop strobe for the input channel addressed by an INPUT
  always_comb
    for (int i = 0; i < N_IN; i++)
      rd_pulse[i] = read_strobe && !special && port_id == IN_BASE + 8'(i);
  // read mux: control registers first, then input channels, everything else reads zero
  always_comb begin
    rd_mux = 8'h00;
    for (int i = 0; i < N_IN; i++) if (!special && port_id == IN_BASE + 8'(i)) rd_mux = ext_in[8*i +: 8];
    if (port_id == IRQ_STAT_ID) rd_mux = 8'(pending);
    else if (port_id == IRQ_MASK_ID) rd_mux = 8'(mask);
  end
  // output registers with next-cycle valid pulse, and the one-cycle-latency read data register
  always_ff @(posedge clk)
    if (!reset) begin
      out_data <= '0;
      out_valid <= '0;
      in_port <= '0;
    end else begin
      for (int i = 0; i < N_OUT; i++) if (wr_hit[i]) out_data[8*i +: 8] <= out_port;
      out_valid <= wr_hit;
      in_port <= rd_mux;
    end
  kcpsm_irq_ctrl #(.N_IRQ(N_IRQ)) u_irq (
    .clk(clk),
    .reset(reset),
    .irq_src(irq_src),
    .stat_wr(stat_wr),
    .mask_wr(mask_wr),
    .wdata(out_port[N_IRQ-1:0]),
    .interrupt_ack(interrupt_ack),
    .pending(pending),
    .mask(mask),
    .interrupt(interrupt)
  );
`ifdef KCPSM_IO_WDOG_EN
  logic kick;
  logic [23:0] wdog_cnt;
  assign kick = write_strobe && wdog_hit;
  // free-running timeout counter; a kick in the expiry cycle suppresses the pulse
  always_ff @(posedge clk)
    if (!reset) begin
      wdog_cnt <= '0;
      wdog_rst <= 1'b0;
    end else begin
      wdog_rst <= !kick && wdog_cnt == 24'(WDOG_CYCLES - 1);
      wdog_cnt <= (kick || wdog_cnt == 24'(WDOG_CYCLES - 1)) ? '0 : wdog_cnt + 24'd1;
    end
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYCLES == 0) || (WDOG_ID == 8'h00);
  assign wdog_rst = 1'b0;
`endif
endmodule
